// File: rtl/mult_rr_scheduler_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
// The result register is modelled as a two-state FSM.
package mult_pkg;

  localparam int N_DEF    = 8;
  localparam int NREQ_DEF = 4;

  typedef logic [N_DEF-1:0]   operand_t;
  typedef logic [2*N_DEF-1:0] product_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/mult_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping modulo NREQ. The one-hot grant is suppressed when en is low.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  logic [IDW-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest valid requester wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
    gnt_onehot = '0;
    if (en && gnt_any) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mult_rr_scheduler_multiplier.sv
// Plain unsigned combinational multiplier producing the full 2*N-bit product.
module multiplier #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one multiplier among NREQ valid/ready requesters via round-robin arbitration,
// returning each product with its requester ID through a one-entry output register.
module mult_rr_scheduler
  import mult_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_p,
  output logic              busy,
  output state_e            fsm_state
);

  // Handshake: a request moves on a clock edge where req_valid[i] && req_ready[i];
  // a result leaves on an edge where rsp_valid && rsp_ready. Requesters hold valid
  // and operands stable until accepted.

  state_e         state;
  logic [IDW-1:0] ptr;
  logic           accept;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           transfer;
  logic [N-1:0]   a_sel;
  logic [N-1:0]   b_sel;
  logic [2*N-1:0] prod;

  // The register can take a new product when empty or when its current one drains this cycle.
  assign accept   = !rst && (state == EMPTY || rsp_ready);
  assign transfer = accept && gnt_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (req_valid),
    .ptr        (ptr),
    .en         (accept),
    .gnt_onehot (req_ready),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign a_sel = req_a[int'(gnt_idx)*N +: N];
  assign b_sel = req_b[int'(gnt_idx)*N +: N];

  multiplier #(
    .N (N)
  ) u_mult (
    .a (a_sel),
    .b (b_sel),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      rsp_id <= '0;
      rsp_p  <= '0;
      ptr    <= '0;
    end else if (transfer) begin
      state  <= FULL;
      rsp_id <= gnt_idx;
      rsp_p  <= prod;
      ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);
  assign busy      = rsp_valid | (|req_valid);
  assign fsm_state = state;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed and random checks of mult_rr_scheduler against a queue-based reference model.
module tb_mult_rr_scheduler;
  import mult_pkg::*;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + 2*N;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_p;
  logic              busy;
  state_e            fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0]    exp_q[$];
  int              m_ptr = 0;
  logic [NREQ-1:0] taken = '0;
  logic            rnd_on = 1'b0;

  mult_rr_scheduler #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*N +: N] = N'(a);
    req_b[i*N +: N] = N'(b);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    @(negedge clk);
    check("rst_req_ready_low", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_p", 64'(rsp_p), 64'(0));
    check("rst_state", 64'(fsm_state), 64'(EMPTY));
    rst = 1'b0; req_valid = '0;
  endtask

  // Reference model: results accepted but not yet delivered sit in exp_q (capacity one).
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic full;
    int unsigned av, bv;
    full = (exp_q.size() != 0);
    if (rst) begin
      check("req_ready_in_rst", 64'(req_ready), 64'(0));
      exp_q.delete();
      m_ptr = 0;
      taken = '0;
    end else begin
      check("rsp_valid", 64'(rsp_valid), 64'(full));
      g = -1;
      if (!full || rsp_ready) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && req_valid[IDW'((m_ptr + k) % NREQ)]) g = (m_ptr + k) % NREQ;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[IDW'(g)] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      taken = exp_rdy;
      if (g >= 0) begin
        av = req_a[g*N +: N];
        bv = req_b[g*N +: N];
        exp_q.push_back({IDW'(g), (2*N)'(av * bv)});
        m_ptr = (g + 1) % NREQ;
      end
    end
  end

  // Output monitor: every presented result must match the oldest expected entry.
  always @(negedge clk) begin
    #1;
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got id %0d p %0d expected no response", rsp_id, rsp_p);
      end else begin
        check("rsp_id", 64'(rsp_id), 64'(exp_q[0][W-1 -: IDW]));
        check("rsp_p", 64'(rsp_p), 64'(exp_q[0][2*N-1:0]));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Random driver: keeps a pending request stable until it is taken.
  always @(posedge clk) begin
    #1;
    if (rnd_on) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || taken[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          set_ops(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset with all requesters valid, then first grant goes to requester 0
    for (int i = 0; i < NREQ; i++) set_ops(i, 10 + i, 20 + i);
    do_reset();
    req_valid = '1;
    @(negedge clk);
    check("t1_first_grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    check("t1_rsp_id", 64'(rsp_id), 64'(0));
    check("t1_rsp_p", 64'(rsp_p), 64'(200));

    // Single requester, maximum operands, held valid
    do_reset();
    req_valid = 4'b0100; set_ops(2, 255, 255); rsp_ready = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check("t2_valid", 64'(rsp_valid), 64'(1));
      check("t2_id", 64'(rsp_id), 64'(2));
      check("t2_p", 64'(rsp_p), 64'(65025));
    end
    @(posedge clk); #1;
    req_valid = '0;

    // Fairness with all valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, i + 1, 3);
    req_valid = '1; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("t3_id", 64'(rsp_id), 64'(k % NREQ));
      check("t3_p", 64'(rsp_p), 64'(((k % NREQ) + 1) * 3));
    end
    @(posedge clk); #1;
    req_valid = '0;

    // Back-pressure while FULL
    do_reset();
    req_valid = 4'b0010; set_ops(1, 5, 3); rsp_ready = 1'b0;
    @(posedge clk); #1;
    set_ops(1, 4, 4);
    repeat (5) begin
      @(negedge clk);
      check("t4_valid", 64'(rsp_valid), 64'(1));
      check("t4_id", 64'(rsp_id), 64'(1));
      check("t4_p", 64'(rsp_p), 64'(15));
      check("t4_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_grant", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("t4_next_p", 64'(rsp_p), 64'(16));

    // Reset mid-stall discards the held result
    do_reset();
    req_valid = 4'b1000; set_ops(3, 6, 7); rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("t5_held_p", 64'(rsp_p), 64'(42));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_valid_cleared", 64'(rsp_valid), 64'(0));
    check("t5_p_cleared", 64'(rsp_p), 64'(0));
    repeat (3) @(negedge clk);

    // Random traffic
    do_reset();
    @(negedge clk);
    rnd_on = 1'b1;
    repeat (1000) @(negedge clk);
    rnd_on = 1'b0;
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    check("drain_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
